// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle RV32I fetch/decode sequencer
// Steps each instruction IDLE->FETCH->DECODE->EXEC->(MEM)->WB; illegal opcodes and memory timeouts trap.
module core_seq_ctrl #(
   parameter int TIMEOUT   = 16,
   parameter int RET_CNT_W = 32
) (
   input  logic                 clk_i,
   input  logic                 SEQrst_i,
   input  logic                 run_i,
   output logic                 imem_req_o,
   input  logic                 imem_valid_i,
   input  logic [31:0]          imem_rdata_i,
   output logic [31:0]          ir_o,
   output logic                 r_en_o,
   output logic                 i_en_o,
   output logic                 s_en_o,
   output logic                 sb_en_o,
   output logic                 u_en_o,
   output logic                 uj_en_o,
   input  logic                 br_taken_i,
   output logic                 be_o,
   output logic                 uje_o,
   output logic                 jalre_o,
   output logic                 pc_en_o,
   output logic [1:0]           pc_sel_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   input  logic                 dmem_valid_i,
   output logic                 rf_we_o,
   output logic                 trap_o,
   output logic [1:0]           cause_o,
   output logic [2:0]           state_o,
   output logic [RET_CNT_W-1:0] retired_o
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t                 r_state, w_next;
   logic [31:0]            r_ir;
   logic [RET_CNT_W-1:0]   r_retired;
   logic                   r_trap;
   logic [1:0]             r_cause, w_cause;
   logic [TW-1:0]          r_tcnt;
   logic                   r_taken;

   logic [4:0] w_opc;
   logic w_lui, w_auipc, w_jal, w_jalr, w_load, w_opimm, w_op, w_store, w_branch;
   logic w_legal, w_active, w_tmo;

   assign w_opc    = r_ir[6:2];
   assign w_lui    = (w_opc == 5'b01101);
   assign w_auipc  = (w_opc == 5'b00101);
   assign w_jal    = (w_opc == 5'b11011);
   assign w_jalr   = (w_opc == 5'b11001);
   assign w_load   = (w_opc == 5'b00000);
   assign w_opimm  = (w_opc == 5'b00100);
   assign w_op     = (w_opc == 5'b01100);
   assign w_store  = (w_opc == 5'b01000);
   assign w_branch = (w_opc == 5'b11000);
   assign w_legal  = (r_ir[1:0] == 2'b11) &
                     (w_lui | w_auipc | w_jal | w_jalr | w_load | w_opimm | w_op | w_store | w_branch);

   // Type enables span DECODE..WB and stay all-zero for an instruction that will trap
   assign w_active = w_legal & ((r_state == S_DECODE) | (r_state == S_EXEC) |
                                (r_state == S_MEM) | (r_state == S_WB));
   assign r_en_o   = w_active & w_op;
   assign i_en_o   = w_active & (w_jalr | w_load | w_opimm);
   assign s_en_o   = w_active & w_store;
   assign sb_en_o  = w_active & w_branch;
   assign u_en_o   = w_active & (w_lui | w_auipc);
   assign uj_en_o  = w_active & w_jal;

   assign w_tmo     = (TIMEOUT > 0) && (r_tcnt == TLIM);
   assign ir_o      = r_ir;
   assign trap_o    = r_trap;
   assign cause_o   = r_cause;
   assign state_o   = r_state;
   assign retired_o = r_retired;

   always_comb begin
      w_next     = r_state;
      w_cause    = r_cause;
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      pc_en_o    = 1'b0;
      pc_sel_o   = 2'b00;
      be_o       = 1'b0;
      uje_o      = 1'b0;
      jalre_o    = 1'b0;
      rf_we_o    = 1'b0;
      case (r_state)
         S_IDLE: if (run_i) w_next = S_FETCH;
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_valid_i) w_next = S_DECODE;
            else if (w_tmo) begin
               w_next  = S_TRAP;
               w_cause = 2'b10;
            end
         end
         S_DECODE: begin
            if (w_legal) w_next = S_EXEC;
            else begin
               w_next  = S_TRAP;
               w_cause = 2'b01;
            end
         end
         S_EXEC: w_next = (w_load | w_store) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = w_store;
            if (dmem_valid_i) w_next = S_WB;
            else if (w_tmo) begin
               w_next  = S_TRAP;
               w_cause = 2'b11;
            end
         end
         S_WB: begin
            pc_en_o = 1'b1;
            rf_we_o = ~(w_store | w_branch);
            if (w_branch & r_taken) begin
               pc_sel_o = 2'b01;
               be_o     = 1'b1;
            end else if (w_jal) begin
               pc_sel_o = 2'b10;
               uje_o    = 1'b1;
            end else if (w_jalr) begin
               pc_sel_o = 2'b11;
               jalre_o  = 1'b1;
            end
            w_next = run_i ? S_FETCH : S_IDLE;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (SEQrst_i) begin
         r_state   <= S_IDLE;
         r_ir      <= '0;
         r_retired <= '0;
         r_trap    <= 1'b0;
         r_cause   <= 2'b00;
         r_tcnt    <= '0;
         r_taken   <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_FETCH) && imem_valid_i) r_ir <= imem_rdata_i;
         if (((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state))
            r_tcnt <= '0;
         else if ((r_state == S_FETCH) || (r_state == S_MEM))
            r_tcnt <= r_tcnt + TW'(1);
         if (r_state == S_EXEC) r_taken <= w_branch & br_taken_i;
         if (r_state == S_WB) r_retired <= r_retired + RET_CNT_W'(1);
         if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_trap  <= 1'b1;
            r_cause <= w_cause;
         end
      end
   end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;
   localparam int TMO = 4;
   localparam int RW  = 2;

   logic          clk_i = 1'b0;
   logic          SEQrst_i, run_i, imem_valid_i, br_taken_i, dmem_valid_i;
   logic [31:0]   imem_rdata_i;
   logic          imem_req_o, r_en_o, i_en_o, s_en_o, sb_en_o, u_en_o, uj_en_o;
   logic          be_o, uje_o, jalre_o, pc_en_o, dmem_req_o, dmem_we_o, rf_we_o, trap_o;
   logic [31:0]   ir_o;
   logic [1:0]    pc_sel_o, cause_o;
   logic [2:0]    state_o;
   logic [RW-1:0] retired_o;

   core_seq_ctrl #(.TIMEOUT(TMO), .RET_CNT_W(RW)) dut (
      .clk_i(clk_i), .SEQrst_i(SEQrst_i), .run_i(run_i),
      .imem_req_o(imem_req_o), .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i), .ir_o(ir_o),
      .r_en_o(r_en_o), .i_en_o(i_en_o), .s_en_o(s_en_o), .sb_en_o(sb_en_o), .u_en_o(u_en_o), .uj_en_o(uj_en_o),
      .br_taken_i(br_taken_i), .be_o(be_o), .uje_o(uje_o), .jalre_o(jalre_o),
      .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_valid_i(dmem_valid_i), .rf_we_o(rf_we_o), .trap_o(trap_o), .cause_o(cause_o),
      .state_o(state_o), .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic        taken;
      int          iw;
      int          dw;
      logic [5:0]  en;
      logic [1:0]  sel;
      logic        rf_we;
      int          dcyc;
      logic        we;
   } vec_t;

   vec_t          vecs[10];
   vec_t          sb_q[$];
   int            n_chk = 0;
   int            n_fail = 0;
   logic [31:0]   cfg_instr = 32'h0;
   int            cfg_iw = 0;
   int            cfg_dw = 0;
   logic [RW-1:0] exp_ret = '0;
   logic [5:0]    en6;

   assign en6 = {r_en_o, i_en_o, s_en_o, sb_en_o, u_en_o, uj_en_o};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory models: answer after cfg_iw / cfg_dw request cycles without valid
   initial begin : responder
      int icnt, dcnt;
      icnt = 0; dcnt = 0;
      imem_valid_i = 1'b0; dmem_valid_i = 1'b0; imem_rdata_i = 32'h0;
      forever begin
         @(negedge clk_i);
         if (imem_req_o) begin
            imem_valid_i = (icnt == cfg_iw);
            imem_rdata_i = (icnt == cfg_iw) ? cfg_instr : 32'hDEAD_BEEF;
            icnt++;
         end else begin
            imem_valid_i = 1'b0;
            icnt = 0;
         end
         if (dmem_req_o) begin
            dmem_valid_i = (dcnt == cfg_dw);
            dcnt++;
         end else begin
            dmem_valid_i = 1'b0;
            dcnt = 0;
         end
      end
   end

   task automatic do_vec(input vec_t v, input bit drop_early, input bit keep_run);
      int cyc, ireq, dreq, dwe, rfw;
      bit done;
      vec_t e;
      cyc = 0; ireq = 0; dreq = 0; dwe = 0; rfw = 0; done = 0;
      cfg_instr = v.instr; cfg_iw = v.iw; cfg_dw = v.dw; br_taken_i = v.taken; run_i = 1'b1;
      sb_q.push_back(v);
      while (!done && cyc < 60) begin
         @(negedge clk_i);
         cyc++;
         if (imem_req_o) ireq++;
         if (dmem_req_o) begin
            dreq++;
            if (dmem_we_o) dwe++;
         end
         if (rf_we_o) rfw++;
         if (state_o == 3'd2) begin
            check("decode_en", {26'd0, en6}, {26'd0, v.en});
            if (drop_early) run_i = 1'b0;
         end
         if (pc_en_o) begin
            done = 1;
            e = sb_q.pop_front();
            check("wb_en", {26'd0, en6}, {26'd0, e.en});
            check("pc_sel", {30'd0, pc_sel_o}, {30'd0, e.sel});
            check("be", {31'd0, be_o}, {31'd0, e.sel == 2'b01});
            check("uje", {31'd0, uje_o}, {31'd0, e.sel == 2'b10});
            check("jalre", {31'd0, jalre_o}, {31'd0, e.sel == 2'b11});
            check("rf_we_cnt", rfw, {31'd0, e.rf_we});
            check("ir", ir_o, e.instr);
            check("retired_wb", {30'd0, retired_o}, {30'd0, exp_ret});
            check("latency", cyc, e.iw + 4 + e.dcyc);
            check("imem_req_cyc", ireq, e.iw + 1);
            check("dmem_req_cyc", dreq, e.dcyc);
            check("dmem_we_cyc", dwe, e.we ? e.dcyc : 0);
            exp_ret = exp_ret + 1'b1;
            run_i = keep_run;
         end
      end
      if (!done) check("wb_reached", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      SEQrst_i = 1'b1;
      run_i = 1'b0;
      @(negedge clk_i);
      SEQrst_i = 1'b0;
      exp_ret = '0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   k, cnt;
      bit   ok;
      vec_t add_v;
      logic [31:0] bad[2];

      vecs[0] = '{32'h002081B3, 1'b0, 1, 0, 6'b100000, 2'b00, 1'b1, 0, 1'b0};
      vecs[1] = '{32'h00208463, 1'b1, 0, 0, 6'b000100, 2'b01, 1'b0, 0, 1'b0};
      vecs[2] = '{32'h00208463, 1'b0, 2, 0, 6'b000100, 2'b00, 1'b0, 0, 1'b0};
      vecs[3] = '{32'h0000A183, 1'b0, 1, 3, 6'b010000, 2'b00, 1'b1, 4, 1'b0};
      vecs[4] = '{32'h0020A023, 1'b1, 0, 0, 6'b001000, 2'b00, 1'b0, 1, 1'b1};
      vecs[5] = '{32'h008000EF, 1'b1, 1, 0, 6'b000001, 2'b10, 1'b1, 0, 1'b0};
      vecs[6] = '{32'h000080E7, 1'b1, 0, 0, 6'b010000, 2'b11, 1'b1, 0, 1'b0};
      vecs[7] = '{32'h123450B7, 1'b0, 0, 0, 6'b000010, 2'b00, 1'b1, 0, 1'b0};
      vecs[8] = '{32'h00108093, 1'b0, 1, 0, 6'b010000, 2'b00, 1'b1, 0, 1'b0};
      vecs[9] = '{32'h00000097, 1'b0, 0, 0, 6'b000010, 2'b00, 1'b1, 0, 1'b0};
      add_v   = vecs[0];
      bad[0]  = 32'hFFFFFFFF;
      bad[1]  = 32'h002081B0;

      SEQrst_i = 1'b1; run_i = 1'b0; br_taken_i = 1'b0;
      repeat (2) @(negedge clk_i);
      SEQrst_i = 1'b0;
      check("rst_state", state_o, 32'd0);
      check("rst_ir", ir_o, 32'd0);
      check("rst_retired", retired_o, 32'd0);
      check("rst_trap", {30'd0, trap_o, cause_o}, 32'd0);
      check("rst_strobes", {imem_req_o, dmem_req_o, pc_en_o, rf_we_o, en6}, 32'd0);
      repeat (2) @(negedge clk_i);
      check("idle_hold", {imem_req_o, state_o}, 32'd0);

      for (int i = 0; i < 10; i++) do_vec(vecs[i], 1'b0, i < 9);
      @(negedge clk_i);
      check("table_idle", state_o, 32'd0);
      check("table_retired", retired_o, exp_ret);

      // run_i dropped mid-instruction: finish it, then park in IDLE
      do_vec(add_v, 1'b1, 1'b0);
      ok = 1;
      repeat (3) begin
         @(negedge clk_i);
         if (state_o != 3'd0 || imem_req_o) ok = 0;
      end
      check("drop_run_idle", ok, 32'd1);

      // Reset in MEM while dmem_valid_i arrives on the same edge
      cfg_instr = 32'h0000A183; cfg_iw = 0; cfg_dw = 0; run_i = 1'b1;
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (state_o != 3'd4 && k < 20);
      check("reach_mem", state_o, 32'd4);
      SEQrst_i = 1'b1; run_i = 1'b0;
      @(negedge clk_i);
      SEQrst_i = 1'b0; exp_ret = '0;
      check("memrst_state", state_o, 32'd0);
      check("memrst_retired", retired_o, 32'd0);
      ok = 1;
      repeat (3) begin
         if (rf_we_o || dmem_req_o || pc_en_o) ok = 0;
         @(negedge clk_i);
      end
      check("memrst_quiet", ok, 32'd1);

      // Illegal instructions trap with cause 01 and hold until reset
      for (int b = 0; b < 2; b++) begin
         cfg_instr = bad[b]; cfg_iw = 0; run_i = 1'b1;
         k = 0;
         do begin
            @(negedge clk_i);
            k++;
         end while (state_o != 3'd6 && k < 20);
         check("ill_state", state_o, 32'd6);
         check("ill_cause", cause_o, 32'd1);
         ok = 1;
         repeat (20) begin
            @(negedge clk_i);
            if (!trap_o || cause_o != 2'b01 || state_o != 3'd6 || imem_req_o || dmem_req_o ||
                pc_en_o || rf_we_o || en6 != 6'd0) ok = 0;
         end
         check("ill_hold", ok, 32'd1);
         do_reset();
         check("ill_rst_state", state_o, 32'd0);
         check("ill_rst_trap", {trap_o, cause_o}, 32'd0);
      end

      // Fetch timeout, then a fetch answered on the last allowed cycle
      cfg_instr = 32'h002081B3; cfg_iw = 1000; run_i = 1'b1;
      cnt = 0; k = 0;
      do begin
         @(negedge clk_i);
         k++;
         if (imem_req_o) cnt++;
      end while (state_o != 3'd6 && k < 30);
      check("itmo_req_cyc", cnt, TMO);
      check("itmo_cause", {trap_o, cause_o}, 32'b110);
      do_reset();
      add_v.iw = TMO - 1;
      do_vec(add_v, 1'b0, 1'b0);
      @(negedge clk_i);
      check("ivalid_wins", {trap_o, state_o}, 32'd0);

      // Data timeout
      cfg_instr = 32'h0000A183; cfg_iw = 0; cfg_dw = 1000; run_i = 1'b1;
      cnt = 0; k = 0;
      do begin
         @(negedge clk_i);
         k++;
         if (dmem_req_o) cnt++;
      end while (state_o != 3'd6 && k < 30);
      check("dtmo_req_cyc", cnt, TMO);
      check("dtmo_cause", {trap_o, cause_o}, 32'b111);
      do_reset();

      // Retired counter wraps modulo 2^RW
      add_v.iw = 0;
      for (int i = 0; i < 5; i++) do_vec(add_v, 1'b0, i < 4);
      @(negedge clk_i);
      check("ret_wrap", retired_o, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
